// File: rtl/morse_serializer.sv
// Serializes a latched 10-bit Morse word (five 2-bit symbols, MSB first) into timed short/long tone enables.
// Optional build macro MORSE_REPEAT_EN: repeat the word after a WORD_TICKS silence while start stays high.
module morse_serializer #(
    parameter int DOT_TICKS   = 4,
    parameter int DASH_TICKS  = 12,
    parameter int GAP_TICKS   = 4,
    parameter int SPACE_TICKS = 12,
    parameter int WORD_TICKS  = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] morse,
    output logic       short,
    output logic       long,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] DOT_N   = (DOT_TICKS   == 0) ? 8'd1 : 8'(DOT_TICKS);
    localparam logic [7:0] DASH_N  = (DASH_TICKS  == 0) ? 8'd1 : 8'(DASH_TICKS);
    localparam logic [7:0] GAP_N   = (GAP_TICKS   == 0) ? 8'd1 : 8'(GAP_TICKS);
    localparam logic [7:0] SPACE_N = (SPACE_TICKS == 0) ? 8'd1 : 8'(SPACE_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TONE,
        S_GAP,
        S_SPACE,
`ifdef MORSE_REPEAT_EN
        S_WORDWAIT,
`endif
        S_FINISH
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [9:0]  sreg, sreg_n;
    logic        dash, dash_n;
    logic        start_q;
    logic        do_dec;

`ifdef MORSE_REPEAT_EN
    localparam logic [7:0] WORD_N = (WORD_TICKS == 0) ? 8'd1 : 8'(WORD_TICKS);
    logic ww_end;
`else
    logic unused_word;
    assign unused_word = (WORD_TICKS != 0);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sreg_n  = sreg;
        dash_n  = dash;
        do_dec  = 1'b0;
`ifdef MORSE_REPEAT_EN
        ww_end  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start && !start_q) begin
                    sreg_n = morse;
                    idx_n  = 3'd0;
                    do_dec = 1'b1;
                end
            end
            S_TONE: begin
                if (cnt == 8'd1) begin
                    sreg_n = {sreg[7:0], 2'b00};
                    idx_n  = idx + 3'd1;
                    // Only a tone following a tone gets a silent gap.
                    if (idx_n != 3'd5 && (sreg_n[9:8] == 2'b01 || sreg_n[9:8] == 2'b10)) begin
                        state_n = S_GAP;
                        cnt_n   = GAP_N;
                    end else begin
                        do_dec = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt == 8'd1) do_dec = 1'b1;
                else             cnt_n  = cnt - 8'd1;
            end
            S_SPACE: begin
                if (cnt == 8'd1) begin
                    sreg_n = {sreg[7:0], 2'b00};
                    idx_n  = idx + 3'd1;
                    do_dec = 1'b1;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
`ifdef MORSE_REPEAT_EN
            // The FINISH cycle counts as the first cycle of the inter-word silence.
            S_FINISH: begin
                if (WORD_N == 8'd1) begin
                    ww_end = 1'b1;
                end else begin
                    state_n = S_WORDWAIT;
                    cnt_n   = WORD_N - 8'd1;
                end
            end
            S_WORDWAIT: begin
                if (cnt == 8'd1) ww_end = 1'b1;
                else             cnt_n  = cnt - 8'd1;
            end
`else
            S_FINISH: state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase

`ifdef MORSE_REPEAT_EN
        if (ww_end) begin
            if (start) begin
                sreg_n = morse;
                idx_n  = 3'd0;
                do_dec = 1'b1;
            end else begin
                state_n = S_IDLE;
            end
        end
`endif

        // Zero-time decode of the symbol now at the top of the shift register.
        if (do_dec) begin
            if (idx_n == 3'd5 || sreg_n[9:8] == 2'b00) begin
                state_n = S_FINISH;
            end else if (sreg_n[9:8] == 2'b01) begin
                state_n = S_TONE;
                dash_n  = 1'b0;
                cnt_n   = DOT_N;
            end else if (sreg_n[9:8] == 2'b10) begin
                state_n = S_TONE;
                dash_n  = 1'b1;
                cnt_n   = DASH_N;
            end else begin
                state_n = S_SPACE;
                cnt_n   = SPACE_N;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            idx     <= 3'd0;
            sreg    <= 10'd0;
            dash    <= 1'b0;
            start_q <= 1'b1;
            short   <= 1'b0;
            long    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sreg    <= sreg_n;
            dash    <= dash_n;
            start_q <= start;
            short   <= (state_n == S_TONE) && !dash_n;
            long    <= (state_n == S_TONE) && dash_n;
            busy    <= (state_n != S_IDLE) && (state_n != S_FINISH);
            done    <= (state_n == S_FINISH);
        end
    end

endmodule
